stream_ctrl: RTL and testbench
==============================

// Module: stream_ctrl
// PURPOSE
//  Sequences the TX sample path: FT245 wrapper -> data_fifo -> modulator.
//  Tracks FIFO occupancy, holds the modulator off until a prefill level is reached,
//  handles underrun stalls and end of stream, and throttles the host with watermarks.
//  Drives modulator.enable and ft245_block.rx_ready_si in top_level.
// PARAMETERS
//  DEPTH_WIDTH   8        FIFO address width; FIFO holds 2**DEPTH_WIDTH bytes
//  START_LEVEL   128      level needed to leave FILL for RUN
//  RESUME_LEVEL  64       level needed to leave STALL for RUN
//  HI_WM         240      host_ready drops when level >= HI_WM
//  LO_WM         192      host_ready rises when level <= LO_WM (LO_WM < HI_WM)
//  TIMEOUT_CLKS  1200000  idle cycles before FILL flushes to RUN or STALL ends stream
//  CNT_W         16       underrun counter width
// PORTS
//  clk           in   1              system clock (PLL output)
//  rst           in   1              asynchronous, active-low reset
//  arm           in   1              1 = streaming allowed; 0 = force IDLE
//  fifo_wr       in   1              FIFO write strobe (rx_valid_si)
//  fifo_rd       in   1              FIFO read strobe (modulator read)
//  fifo_empty    in   1              FIFO empty_o
//  fifo_full     in   1              FIFO full_o
//  mod_enable    out  1              modulator enable
//  host_ready    out  1              to rx_ready_si; AND with !fifo_full externally
//  level         out  DEPTH_WIDTH+1  FIFO occupancy (0 .. 2**DEPTH_WIDTH)
//  state         out  2              0=IDLE 1=FILL 2=RUN 3=STALL
//  underrun_cnt  out  CNT_W          count of RUN->STALL transitions, saturating
//  eos           out  1              one-cycle pulse on STALL->IDLE timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, level=0, mod_enable=0, host_ready=1,
//   underrun_cnt=0, eos=0, timeout counter=0. All outputs are registered.
//  Occupancy:
//   - wr_q = fifo_wr & !fifo_full; rd_q = fifo_rd & !fifo_empty.
//   - wr_q & !rd_q -> level+1; rd_q & !wr_q -> level-1; both or neither -> hold.
//   - level never wraps: clamp at 0 and 2**DEPTH_WIDTH.
//  host_ready: hysteresis on level after update; between LO_WM and HI_WM it holds.
//  FSM (next state uses the current registered level; outputs 1 cycle after decision):
//   - IDLE:  mod_enable=0; arm & level!=0 -> FILL, timeout counter cleared.
//   - FILL:  mod_enable=0; level>=START_LEVEL -> RUN;
//            else counter reaches TIMEOUT_CLKS with level!=0 -> RUN (short-message flush).
//   - RUN:   mod_enable=1; fifo_empty & !wr_q -> STALL, underrun_cnt+1 (saturates at all-ones).
//   - STALL: mod_enable=0; counter cleared on entry;
//            level>=RESUME_LEVEL -> RUN; counter reaches TIMEOUT_CLKS -> IDLE and eos=1
//            for one cycle (if level!=0 then, IDLE -> FILL next cycle).
//  Timeout counter: counts in FILL/STALL only; cleared on every state change and on any wr_q.
//  arm=0 in any state: IDLE next cycle, mod_enable=0; level tracking continues; no eos.
//  Simultaneous events: arm=0 beats everything; in STALL, resume beats timeout.
//  In RUN, empty with a write in the same cycle does not stall.
//  Any reset mid-operation returns to reset values immediately; no other state is kept.
// TESTING
//  1 Reset, arm=1, write 128 bytes with no reads -> FILL at level 1; RUN and mod_enable=1
//    one cycle after level=128.
//  2 Write 240 bytes -> host_ready=0 at level 240; read down to 192 -> host_ready=1.
//  3 RUN, stop writes, drain to empty -> STALL, underrun_cnt=1, mod_enable=0;
//    write 64 -> RUN.
//  4 STALL, no writes for TIMEOUT_CLKS (set 100 in bench) -> eos pulse 1 cycle, state=IDLE.
//  5 Write 10 bytes then idle -> FILL for TIMEOUT_CLKS, then RUN with level=10.
//  6 Same-cycle wr/rd at level 5 -> level 5; rst low mid-RUN -> all outputs at reset values
//    asynchronously; arm=0 mid-RUN -> IDLE, level preserved.

Source files
------------

// File: rtl/stream_ctrl.sv
// TX stream sequencer: tracks FIFO occupancy, gates the modulator through
// IDLE/FILL/RUN/STALL, and throttles the host with level watermarks.
module stream_ctrl #(
    parameter int DEPTH_WIDTH  = 8,
    parameter int START_LEVEL  = 128,
    parameter int RESUME_LEVEL = 64,
    parameter int HI_WM        = 240,
    parameter int LO_WM        = 192,
    parameter int TIMEOUT_CLKS = 1200000,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   fifo_wr,
    input  logic                   fifo_rd,
    input  logic                   fifo_empty,
    input  logic                   fifo_full,
    output logic                   mod_enable,
    output logic                   host_ready,
    output logic [DEPTH_WIDTH:0]   level,
    output logic [1:0]             state,
    output logic [CNT_W-1:0]       underrun_cnt,
    output logic                   eos
);

    localparam int LW = DEPTH_WIDTH + 1;
    localparam int TW = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);

    localparam logic [LW-1:0]    LEVEL_MAX = LW'(1 << DEPTH_WIDTH);
    localparam logic [LW-1:0]    START_LV  = LW'(START_LEVEL);
    localparam logic [LW-1:0]    RESUME_LV = LW'(RESUME_LEVEL);
    localparam logic [LW-1:0]    HI_LV     = LW'(HI_WM);
    localparam logic [LW-1:0]    LO_LV     = LW'(LO_WM);
    localparam logic [LW-1:0]    LV_ONE    = LW'(1);
    localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0]    TO_ONE    = TW'(1);
    localparam logic [CNT_W-1:0] UR_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [LW-1:0]     level_reg, level_next;
    logic              host_ready_reg, host_ready_next;
    logic              mod_enable_reg, mod_enable_next;
    logic [CNT_W-1:0]  underrun_reg, underrun_next;
    logic              eos_reg, eos_next;
    logic [TW-1:0]     tmo_reg, tmo_next;

    logic wr_q;
    logic rd_q;
    logic to_hit;

    assign wr_q   = fifo_wr & ~fifo_full;
    assign rd_q   = fifo_rd & ~fifo_empty;
    assign to_hit = (tmo_reg == TO_LAST);

    // Occupancy and host throttle; the watermark sees the updated level.
    always_comb begin
        level_next      = level_reg;
        host_ready_next = host_ready_reg;
        if (wr_q && !rd_q && level_reg != LEVEL_MAX) begin
            level_next = level_reg + LV_ONE;
        end else if (rd_q && !wr_q && level_reg != '0) begin
            level_next = level_reg - LV_ONE;
        end
        if (level_next >= HI_LV) begin
            host_ready_next = 1'b0;
        end else if (level_next <= LO_LV) begin
            host_ready_next = 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        underrun_next = underrun_reg;
        eos_next      = 1'b0;
        if (!arm) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (level_reg != '0) state_next = FILL;
                end
                FILL: begin
                    if (level_reg >= START_LV) begin
                        state_next = RUN;
                    end else if (to_hit && level_reg != '0) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (fifo_empty && !wr_q) begin
                        state_next = STALL;
                        if (underrun_reg != '1) underrun_next = underrun_reg + UR_ONE;
                    end
                end
                STALL: begin
                    if (level_reg >= RESUME_LV) begin
                        state_next = RUN;
                    end else if (to_hit) begin
                        state_next = IDLE;
                        eos_next   = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        mod_enable_next = (state_next == RUN);

        // Idle timer only runs while waiting in FILL/STALL with no host traffic.
        tmo_next = tmo_reg;
        if (state_next != state_reg || wr_q ||
            !(state_reg == FILL || state_reg == STALL)) begin
            tmo_next = '0;
        end else if (!to_hit) begin
            tmo_next = tmo_reg + TO_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            level_reg      <= '0;
            host_ready_reg <= 1'b1;
            mod_enable_reg <= 1'b0;
            underrun_reg   <= '0;
            eos_reg        <= 1'b0;
            tmo_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            level_reg      <= level_next;
            host_ready_reg <= host_ready_next;
            mod_enable_reg <= mod_enable_next;
            underrun_reg   <= underrun_next;
            eos_reg        <= eos_next;
            tmo_reg        <= tmo_next;
        end
    end

    assign state        = state_reg;
    assign level        = level_reg;
    assign host_ready   = host_ready_reg;
    assign mod_enable   = mod_enable_reg;
    assign underrun_cnt = underrun_reg;
    assign eos          = eos_reg;

endmodule

// File: tb/tb_stream_ctrl.sv
// Directed bench for stream_ctrl: FIFO flags come from a bench-side occupancy
// counter; every expectation is a hand-computed constant.
module tb_stream_ctrl;

    localparam int T = 100;

    logic        clk;
    logic        rst;
    logic        arm;
    logic        fifo_wr;
    logic        fifo_rd;
    logic        fifo_empty;
    logic        fifo_full;
    logic        mod_enable;
    logic        host_ready;
    logic [8:0]  level;
    logic [1:0]  state;
    logic [15:0] underrun_cnt;
    logic        eos;

    int checks;
    int errors;
    int occ;

    stream_ctrl #(
        .DEPTH_WIDTH(8), .START_LEVEL(128), .RESUME_LEVEL(64),
        .HI_WM(240), .LO_WM(192), .TIMEOUT_CLKS(T), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .mod_enable(mod_enable), .host_ready(host_ready),
        .level(level), .state(state),
        .underrun_cnt(underrun_cnt), .eos(eos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_flags();
        fifo_empty = (occ == 0);
        fifo_full  = (occ == 256);
    endtask

    // One clock with the given strobes; returns at posedge+1 with strobes idle.
    task automatic cycle(input logic wr, input logic rd);
        bit wq, rq;
        fifo_wr = wr;
        fifo_rd = rd;
        set_flags();
        wq = wr && (occ != 256);
        rq = rd && (occ != 0);
        @(posedge clk);
        #1;
        if (wq && !rq) occ++;
        else if (rq && !wq) occ--;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        set_flags();
    endtask

    task automatic do_reset();
        rst = 1'b0; arm = 1'b0; fifo_wr = 1'b0; fifo_rd = 1'b0;
        occ = 0;
        set_flags();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check("rst_state", int'(state), 0);
        check("rst_level", int'(level), 0);
        check("rst_mod_enable", int'(mod_enable), 0);
        check("rst_host_ready", int'(host_ready), 1);
        check("rst_underrun", int'(underrun_cnt), 0);
        check("rst_eos", int'(eos), 0);
        $display("test_reset done");
    endtask

    task automatic test_fill_run();
        arm = 1'b1;
        cycle(1'b1, 1'b0);
        check("fill_l1_state", int'(state), 0);
        check("fill_l1_level", int'(level), 1);
        cycle(1'b1, 1'b0);
        check("fill_l2_state", int'(state), 1);
        for (int i = 3; i <= 128; i++) cycle(1'b1, 1'b0);
        check("fill_l128_level", int'(level), 128);
        check("fill_l128_state", int'(state), 1);
        check("fill_l128_mod", int'(mod_enable), 0);
        cycle(1'b0, 1'b0);
        check("run_state", int'(state), 2);
        check("run_mod", int'(mod_enable), 1);
        $display("test_fill_run done level=%0d state=%0d", level, state);
    endtask

    task automatic test_watermark();
        while (occ < 239) cycle(1'b1, 1'b0);
        check("wm_239_ready", int'(host_ready), 1);
        cycle(1'b1, 1'b0);
        check("wm_240_level", int'(level), 240);
        check("wm_240_ready", int'(host_ready), 0);
        while (occ < 256) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("wm_full_clamp", int'(level), 256);
        while (occ > 193) cycle(1'b0, 1'b1);
        check("wm_193_ready", int'(host_ready), 0);
        cycle(1'b0, 1'b1);
        check("wm_192_level", int'(level), 192);
        check("wm_192_ready", int'(host_ready), 1);
        $display("test_watermark done level=%0d ready=%0d", level, host_ready);
    endtask

    task automatic test_underrun();
        while (occ > 0) cycle(1'b0, 1'b1);
        check("ur_drained_state", int'(state), 2);
        cycle(1'b1, 1'b0);
        check("ur_empty_wr_state", int'(state), 2);
        check("ur_empty_wr_level", int'(level), 1);
        cycle(1'b0, 1'b1);
        check("ur_floor_level", int'(level), 0);
        cycle(1'b0, 1'b0);
        check("ur_stall_state", int'(state), 3);
        check("ur_stall_cnt", int'(underrun_cnt), 1);
        check("ur_stall_mod", int'(mod_enable), 0);
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0);
        check("ur_l64_state", int'(state), 3);
        cycle(1'b0, 1'b0);
        check("ur_resume_state", int'(state), 2);
        check("ur_resume_mod", int'(mod_enable), 1);
        $display("test_underrun done underrun_cnt=%0d", underrun_cnt);
    endtask

    task automatic test_stall_timeout();
        while (occ > 0) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("to_stall_state", int'(state), 3);
        check("to_stall_cnt", int'(underrun_cnt), 2);
        for (int i = 0; i < T - 1; i++) cycle(1'b0, 1'b0);
        check("to_pre_state", int'(state), 3);
        check("to_pre_eos", int'(eos), 0);
        cycle(1'b0, 1'b0);
        check("to_idle_state", int'(state), 0);
        check("to_eos_pulse", int'(eos), 1);
        cycle(1'b0, 1'b0);
        check("to_eos_clear", int'(eos), 0);
        check("to_idle_hold", int'(state), 0);
        $display("test_stall_timeout done state=%0d", state);
    endtask

    task automatic test_flush();
        do_reset();
        arm = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        check("fl_level", int'(level), 10);
        check("fl_state", int'(state), 1);
        for (int i = 0; i < T - 1; i++) cycle(1'b0, 1'b0);
        check("fl_pre_state", int'(state), 1);
        cycle(1'b0, 1'b0);
        check("fl_run_state", int'(state), 2);
        check("fl_run_level", int'(level), 10);
        check("fl_run_mod", int'(mod_enable), 1);
        $display("test_flush done level=%0d state=%0d", level, state);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        check("b2b_level", int'(level), 5);
        arm = 1'b0;
        cycle(1'b0, 1'b0);
        check("disarm_state", int'(state), 0);
        check("disarm_mod", int'(mod_enable), 0);
        check("disarm_level", int'(level), 5);
        check("disarm_eos", int'(eos), 0);
        cycle(1'b1, 1'b0);
        check("disarm_track", int'(level), 6);
        check("disarm_hold", int'(state), 0);
        arm = 1'b1;
        cycle(1'b0, 1'b0);
        check("rearm_state", int'(state), 1);
        while (occ < 128) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("rearm_run", int'(state), 2);
        #2;
        rst = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_level", int'(level), 0);
        check("async_mod", int'(mod_enable), 0);
        check("async_ready", int'(host_ready), 1);
        check("async_underrun", int'(underrun_cnt), 0);
        check("async_eos", int'(eos), 0);
        occ = 0;
        set_flags();
        @(negedge clk);
        rst = 1'b1;
        $display("test_back_to_back done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill_run();
        test_watermark();
        test_underrun();
        test_stall_timeout();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
